// File: rtl/egg_countdown_if.sv
// Control and display signals between the egg-timer front panel and the countdown core.
// The master drives commands and the slow clock level; the slave returns the count and status flags.
interface egg_countdown_if;
    logic       slow_clk;
    logic       load;
    logic       start;
    logic       stop;
    logic [6:0] set_min;
    logic [5:0] set_sec;
    logic [6:0] min_out;
    logic [5:0] sec_out;
    logic       running;
    logic       alarm;
    logic       done;

    modport master (
        output slow_clk, load, start, stop, set_min, set_sec,
        input  min_out, sec_out, running, alarm, done
    );

    modport slave (
        input  slow_clk, load, start, stop, set_min, set_sec,
        output min_out, sec_out, running, alarm, done
    );
endinterface

// File: rtl/egg_countdown.sv
// Egg-timer countdown core: turns slow_clk rising edges into ticks, counts mm:ss down to zero,
// then holds a timed alarm. Every output comes straight from a flop.
module egg_countdown #(
    parameter int MAX_MIN    = 99,
    parameter int ALARM_SECS = 10
) (
    input  logic            clk_in,
    input  logic            reset,
    egg_countdown_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, ALARM} state_t;

    state_t     state_q, state_d;
    logic       slow_clk_q;
    logic [6:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic [7:0] alarm_cnt_q, alarm_cnt_d;
    logic       running_q, alarm_q, done_q, done_d;

    logic       tick;
    logic       count_zero;
    logic [6:0] load_min;
    logic [5:0] load_sec;

    assign tick       = bus.slow_clk & ~slow_clk_q;
    assign count_zero = (min_q == 7'd0) && (sec_q == 6'd0);
    assign load_min   = (bus.set_min > 7'(MAX_MIN)) ? 7'(MAX_MIN) : bus.set_min;
    assign load_sec   = (bus.set_sec > 6'd59) ? 6'd59 : bus.set_sec;

    // Command priority is stop > load > start > tick; a stop always blocks lower commands.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        min_d       = min_q;
        sec_d       = sec_q;
        alarm_cnt_d = alarm_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.stop) begin
                    if (bus.load) begin
                        min_d = load_min;
                        sec_d = load_sec;
                    end else if (bus.start && !count_zero) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = PAUSED;
                end else if (tick) begin
                    if (sec_q != 6'd0) begin
                        sec_d = sec_q - 6'd1;
                    end else if (min_q != 7'd0) begin
                        min_d = min_q - 7'd1;
                        sec_d = 6'd59;
                    end
                    if (min_d == 7'd0 && sec_d == 6'd0) begin
                        state_d     = ALARM;
                        done_d      = 1'b1;
                        alarm_cnt_d = 8'd0;
                    end
                end
            end
            PAUSED: begin
                if (!bus.stop) begin
                    if (bus.load) begin
                        min_d   = load_min;
                        sec_d   = load_sec;
                        state_d = IDLE;
                    end else if (bus.start && !count_zero) begin
                        state_d = RUN;
                    end
                end
            end
            ALARM: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    alarm_cnt_d = alarm_cnt_q + 8'd1;
                    if (alarm_cnt_d == 8'(ALARM_SECS)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            // Reset high so a slow_clk already at 1 is not mistaken for a rising edge.
            slow_clk_q  <= 1'b1;
            min_q       <= 7'd0;
            sec_q       <= 6'd0;
            alarm_cnt_q <= 8'd0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            state_q     <= state_d;
            slow_clk_q  <= bus.slow_clk;
            min_q       <= min_d;
            sec_q       <= sec_d;
            alarm_cnt_q <= alarm_cnt_d;
            running_q   <= (state_d == RUN);
            alarm_q     <= (state_d == ALARM);
            done_q      <= done_d;
        end
    end

    assign bus.min_out = min_q;
    assign bus.sec_out = sec_q;
    assign bus.running = running_q;
    assign bus.alarm   = alarm_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_egg_countdown.sv
// Bench for egg_countdown: a total-seconds reference model compared every cycle,
// plus directed scenarios with hand-computed expected outputs.
module tb_egg_countdown;

    localparam int MAX_MIN    = 99;
    localparam int ALARM_SECS = 10;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_ALARM  = 3;

    logic clk_in = 1'b0;
    logic reset;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    egg_countdown_if bus();

    egg_countdown #(.MAX_MIN(MAX_MIN), .ALARM_SECS(ALARM_SECS)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int mode;
        int total;
        int acnt;
        bit done;
        bit prev;
    } model_t;

    model_t m = '{mode: M_IDLE, total: 0, acnt: 0, done: 1'b0, prev: 1'b1};

    // Reference works in whole seconds; minutes/seconds are derived only for comparison.
    function automatic model_t model_step(model_t s, bit rst, bit slow, bit ld, bit st, bit sp,
                                          int smin, int ssec);
        model_t n = s;
        bit tk;
        int load_total;
        n.done = 1'b0;
        if (rst) begin
            n.mode  = M_IDLE;
            n.total = 0;
            n.acnt  = 0;
            n.prev  = 1'b1;
            return n;
        end
        tk         = slow && !s.prev;
        n.prev     = slow;
        load_total = ((smin > MAX_MIN) ? MAX_MIN : smin) * 60 + ((ssec > 59) ? 59 : ssec);
        case (s.mode)
            M_IDLE: begin
                if (!sp && ld) n.total = load_total;
                else if (!sp && st && s.total != 0) n.mode = M_RUN;
            end
            M_RUN: begin
                if (sp) n.mode = M_PAUSED;
                else if (tk) begin
                    n.total = s.total - 1;
                    if (n.total == 0) begin
                        n.mode = M_ALARM;
                        n.done = 1'b1;
                        n.acnt = 0;
                    end
                end
            end
            M_PAUSED: begin
                if (!sp && ld) begin
                    n.total = load_total;
                    n.mode  = M_IDLE;
                end else if (!sp && st && s.total != 0) n.mode = M_RUN;
            end
            default: begin
                if (sp) n.mode = M_IDLE;
                else if (tk) begin
                    n.acnt = s.acnt + 1;
                    if (n.acnt == ALARM_SECS) n.mode = M_IDLE;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [31:0] pack(int mn, int sc, bit r, bit a, bit d);
        return {16'd0, 7'(mn), 6'(sc), r, a, d};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {16'd0, bus.min_out, bus.sec_out, bus.running, bus.alarm, bus.done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_in) begin
        m <= model_step(m, reset, bus.slow_clk, bus.load, bus.start, bus.stop,
                        int'(bus.set_min), int'(bus.set_sec));
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            check("model", dut_vec(),
                  pack(m.total / 60, m.total % 60, m.mode == M_RUN, m.mode == M_ALARM, m.done));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_load(input int mn, input int sc);
        bus.set_min = 7'(mn);
        bus.set_sec = 6'(sc);
        bus.load    = 1'b1;
        cyc(1);
        bus.load    = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
    endtask

    task automatic slow_period();
        bus.slow_clk = 1'b1;
        cyc(9);
        bus.slow_clk = 1'b0;
        cyc(9);
    endtask

    task automatic expect_out(input string name, input int mn, input int sc,
                              input bit r, input bit a, input bit d);
        @(negedge clk_in);
        check(name, dut_vec(), pack(mn, sc, r, a, d));
    endtask

    initial begin
        reset        = 1'b1;
        bus.slow_clk = 1'b1;
        bus.load     = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.set_min  = 7'd0;
        bus.set_sec  = 6'd0;
        cyc(2);
        chk_en = 1'b1;

        // Reset release with slow_clk already high: no tick, all zero
        reset = 1'b0;
        cyc(5);
        expect_out("t1_reset_hold", 0, 0, 0, 0, 0);

        // 0:03 countdown into alarm, then alarm timeout
        bus.slow_clk = 1'b0;
        cyc(2);
        do_load(0, 3);
        expect_out("t2_loaded", 0, 3, 0, 0, 0);
        do_start();
        expect_out("t2_run", 0, 3, 1, 0, 0);
        slow_period();
        expect_out("t2_tick1", 0, 2, 1, 0, 0);
        slow_period();
        expect_out("t2_tick2", 0, 1, 1, 0, 0);
        bus.slow_clk = 1'b1;
        cyc(1);
        expect_out("t2_alarm_entry", 0, 0, 0, 1, 1);
        cyc(1);
        expect_out("t2_done_one_cycle", 0, 0, 0, 1, 0);
        cyc(7);
        bus.slow_clk = 1'b0;
        cyc(9);
        repeat (9) slow_period();
        expect_out("t2_alarm_after_9", 0, 0, 0, 1, 0);
        slow_period();
        expect_out("t2_alarm_timeout", 0, 0, 0, 0, 0);

        // Pause on a tick cycle discards the tick; resume continues
        do_load(1, 0);
        do_start();
        slow_period();
        expect_out("t3_borrow", 0, 59, 1, 0, 0);
        bus.slow_clk = 1'b1;
        bus.stop     = 1'b1;
        cyc(1);
        bus.stop     = 1'b0;
        expect_out("t3_stop_on_tick", 0, 59, 0, 0, 0);
        cyc(8);
        bus.slow_clk = 1'b0;
        cyc(9);
        do_start();
        expect_out("t3_resumed", 0, 59, 1, 0, 0);
        slow_period();
        expect_out("t3_next_tick", 0, 58, 1, 0, 0);

        // Clipping on load from PAUSED, load ignored in RUN
        do_stop();
        do_load(120, 63);
        expect_out("t4_clip", 99, 59, 0, 0, 0);
        do_start();
        do_load(5, 5);
        expect_out("t4_load_in_run", 99, 59, 1, 0, 0);
        do_stop();

        // Zero load blocks start; stop silences alarm
        do_load(0, 0);
        do_start();
        expect_out("t5_zero_start", 0, 0, 0, 0, 0);
        do_load(0, 1);
        do_start();
        bus.slow_clk = 1'b1;
        cyc(1);
        expect_out("t5_alarm", 0, 0, 0, 1, 1);
        do_stop();
        expect_out("t5_stop_alarm", 0, 0, 0, 0, 0);
        cyc(7);
        bus.slow_clk = 1'b0;
        cyc(9);

        // Reset mid-run, then start ignored until reload
        do_load(0, 46);
        do_start();
        slow_period();
        expect_out("t6_pre_reset", 0, 45, 1, 0, 0);
        bus.slow_clk = 1'b1;
        reset        = 1'b1;
        cyc(1);
        reset        = 1'b0;
        expect_out("t6_reset", 0, 0, 0, 0, 0);
        do_start();
        expect_out("t6_start_ignored", 0, 0, 0, 0, 0);
        do_load(0, 2);
        do_start();
        expect_out("t6_reload_run", 0, 2, 1, 0, 0);
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/egg_countdown.md
Name: egg_countdown

Overview:
Countdown core of the egg timer. Consumes the divided 1 Hz-class clock from the clock divider stage as a level on `slow_clk`. It converts each rising edge of that level into a single-cycle tick in the `clk_in` domain. On each tick it decrements a minutes:seconds counter, then raises a timed alarm when the count reaches 00:00. The outputs feed the display decoder and the buzzer driver.

Parameters:
MAX_MIN, 99, largest loadable minutes value; larger `set_min` is clipped to this.
ALARM_SECS, 10, number of ticks the alarm stays asserted before auto-return to IDLE (1..255).

Ports:
clk_in  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
slow_clk  input  1  divided clock level from the divider; synchronous to clk_in.
load  input  1  load `set_min`/`set_sec` into the counter.
start  input  1  begin or resume the countdown.
stop  input  1  pause the countdown, or silence the alarm.
set_min  input  7  minutes to load.
set_sec  input  6  seconds to load.
min_out  output  7  current minutes.
sec_out  output  6  current seconds.
running  output  1  high while in RUN.
alarm  output  1  high while in ALARM.
done  output  1  one-cycle pulse on entry to ALARM.

Behaviour:
- One clock `clk_in`. Reset is synchronous and active-high; it is named `reset`.
- Reset values:
  - state = IDLE; `min_out` = 0; `sec_out` = 0; `running` = 0; `alarm` = 0; `done` = 0; alarm counter = 0.
  - `slow_clk_q` = 1, so no tick is generated in the first cycle after reset even if `slow_clk` = 1.
- Tick generation:
  - `slow_clk_q` <= `slow_clk` every cycle.
  - tick = `slow_clk` & ~`slow_clk_q`; exactly one `clk_in` cycle per `slow_clk` rising edge.
  - Falling edges are ignored.
- Command priority within a cycle: reset > stop > load > start > tick.
- State IDLE:
  - `load` captures min(`set_min`, MAX_MIN) and min(`set_sec`, 59); state stays IDLE.
  - `start` goes to RUN only if the count is not 00:00; otherwise it is ignored.
  - Ticks are ignored.
- State RUN (`running` = 1):
  - On a tick:
    - if sec > 0: sec - 1;
    - else if min > 0: min - 1 and sec = 59.
  - If the tick produces 00:00, the state becomes ALARM on that same edge.
  - `stop` goes to PAUSED; a tick in the same cycle is discarded and the count is unchanged.
  - `load` and `start` are ignored.
- State PAUSED:
  - The count is held.
  - `load` reloads the count (with clipping) and returns to IDLE.
  - `start` with a nonzero count goes to RUN.
  - `stop` has no effect.
- State ALARM (`alarm` = 1):
  - `done` = 1 only in the first cycle in ALARM.
  - The alarm counter is cleared on entry and increments on each tick.
  - When it reaches ALARM_SECS, the state goes to IDLE and `alarm` = 0 on the next cycle.
  - `stop` goes to IDLE immediately.
  - `load` and `start` are ignored. The count stays 00:00.
- Entering RUN or ALARM does not consume the current tick. Counting starts at the next rising edge of `slow_clk`.
- `min_out`/`sec_out` are registered and reflect the counter directly: zero added latency after the edge that updates them.
- Loading 00:00 is legal; `start` then does nothing.
- Reset mid-RUN or mid-ALARM returns everything to reset values on the next edge.

Test Plan:
1. Reset, `slow_clk` held 1 for 5 cycles -> no tick; `min_out` = 0, `sec_out` = 0, all flags 0.
2. `slow_clk` toggling every 9 `clk_in` cycles (period 18), load 0:03, start:
   - count reads 0:02 after the 1st rising edge and 0:01 after the 2nd;
   - after the 3rd edge: 0:00, `alarm` = 1, `done` high for exactly 1 cycle.
   - After a further 10 rising edges, `alarm` = 0 and the state is IDLE.
3. Load 1:00, start, 1 tick -> 0:59; stop asserted on a tick cycle -> count stays 0:59, `running` = 0; start -> resumes, next tick 0:58.
4. Load `set_min` = 120, `set_sec` = 63 -> `min_out` = 99, `sec_out` = 59; load while RUN -> ignored.
5. Load 0:00, start -> remains IDLE, `running` = 0. Then load 0:01, start, tick -> ALARM; stop during ALARM -> `alarm` = 0 next cycle.
6. Reset asserted mid-RUN at 0:45 -> next cycle 0:00, IDLE; start then ignored until a new load.
